// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU/MDU: base op codes, M-extension
// funct3 codes and the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/alu_mdu_seq_if.sv
// Request/response handshake bundle between the execute stage and the ALU/MDU.
interface alu_mdu_seq_if #(parameter int XLEN = 32) ();
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (output in_valid, op, a, b, out_ready,
                    input  in_ready, out_valid, result);
    modport slave  (input  in_valid, op, a, b, out_ready,
                    output in_ready, out_valid, result);
endinterface

// File: rtl/alu_base_comb.sv
// Combinational RV32I-style base ALU, width-parametrised; unknown codes give 0.
module alu_base_comb
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [SHW-1:0]         shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[SHW-1:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = a_s >>> shamt;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  y = a ^ b;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/alu_mdu_seq.sv
// Execute-stage ALU with iterative RV32M multiply/divide behind a valid/ready
// handshake. Base ops finish in one cycle; M ops take XLEN iterations plus fix-up.
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input logic          clk,
    input logic          rst_n,
    input logic          flush,
    alu_mdu_seq_if.slave bus
);
    logic [1:0]          state_q, state_d;
    logic [4:0]          op_q, op_d;
    logic [SHW-1:0]      cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     dvs_q, dvs_d;
    logic                neg_q, neg_d;
    logic                negr_q, negr_d;
    logic [XLEN-1:0]     res_q, res_d;

    logic [XLEN-1:0]     base_y;
    logic [2:0]          f3;
    logic                sa, sb, a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0]     a_mag, b_mag, special_y, fix_y;
    logic [XLEN:0]       mul_sum, div_shift, div_trial;
    logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix;

    alu_base_comb #(.XLEN(XLEN), .SHW(SHW)) u_base (
        .op (bus.op[3:0]),
        .a  (bus.a),
        .b  (bus.b),
        .y  (base_y)
    );

    assign f3    = bus.op[2:0];
    assign sa    = (f3 == MDU_MULH) || (f3 == MDU_MULHSU) || (f3 == MDU_DIV) || (f3 == MDU_REM);
    assign sb    = (f3 == MDU_MULH) || (f3 == MDU_DIV) || (f3 == MDU_REM);
    assign a_neg = sa && bus.a[XLEN-1];
    assign b_neg = sb && bus.b[XLEN-1];
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;
    assign div0  = f3[2] && (bus.b == '0);
    assign ovf   = f3[2] && !f3[0] && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    // Divide-by-zero and signed overflow resolve without iterating.
    assign special_y = div0 ? (f3[1] ? bus.a : '1) : (f3[1] ? '0 : bus.a);

    // Multiply: acc = {partial high, multiplier}, shift right one bit per cycle.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // Divide: acc = {remainder, dividend/quotient}, restoring step.
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_trial = div_shift - {1'b0, dvs_q};
    assign div_next  = div_trial[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign prod_fix = neg_q  ? -acc_q : acc_q;
    assign quo_fix  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        case (op_q[2:0])
            MDU_MUL:               fix_y = prod_fix[XLEN-1:0];
            MDU_DIV, MDU_DIVU:     fix_y = quo_fix;
            MDU_REM, MDU_REMU:     fix_y = rem_fix;
            default:               fix_y = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d = bus.op;
                    if (!bus.op[4]) begin
                        res_d   = base_y;
                        state_d = DONE;
                    end else if (div0 || ovf) begin
                        res_d   = special_y;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = SHW'(XLEN-1);
                        dvs_d   = f3[2] ? b_mag : a_mag;
                        acc_d   = {{XLEN{1'b0}}, (f3[2] ? a_mag : b_mag)};
                        neg_d   = a_neg ^ b_neg;
                        negr_d  = a_neg;
                    end
                end
            end
            BUSY: begin
                acc_d = op_q[2] ? div_next : mul_next;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                res_d   = fix_y;
                state_d = DONE;
            end
            default: begin
                if (bus.out_ready) state_d = IDLE;
            end
        endcase
        // Abort wins over everything, including an accept this cycle.
        if (flush) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            res_q   <= res_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;
endmodule
